// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command-level controller wrapped around an external combinational 8-bit ALU.
//   Accepts ADC/SBC/AND/ORA/EOR/ASL/CMP/NOP commands over valid/ready, drives the
//   ALU one-hot op and operands, iterates the shifter for multi-bit ASL, derives
//   N/Z/C/V, owns the status flag register and returns result + flags over
//   valid/ready.
//
//   Optional feature macro: ALU_SEQ_CMD_COUNT_EN
//     adds cmd_count[15:0], a wrapping count of completed response transfers.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only while idle)
//   cmd_op, cmd_a, cmd_b, cmd_shamt command fields
//   flags_wr, flags_wr_data         direct flag load {N,V,Z,C}, honoured when idle
//   alu_a, alu_b, alu_op,
//   alu_carry_in                    ALU drive (alu_b already inverted for SBC/CMP)
//   alu_result, alu_carry_out       ALU return
//   rsp_valid/rsp_ready, rsp_data   response handshake and result
//   flag_n/v/z/c                    current status flags
module alu_sequencer #(
  parameter int MAX_SHIFT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_shamt,
  input  logic       flags_wr,
  input  logic [3:0] flags_wr_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_op,
  output logic       alu_carry_in,
  input  logic [7:0] alu_result,
  input  logic       alu_carry_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       flag_n,
  output logic       flag_v,
  output logic       flag_z,
  output logic       flag_c
`ifdef ALU_SEQ_CMD_COUNT_EN
  ,
  output logic [15:0] cmd_count
`endif
);

  localparam logic [2:0] OP_ADC = 3'd0;
  localparam logic [2:0] OP_SBC = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ORA = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_ASL = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;

  localparam logic [4:0] ALU_SUM = 5'b10000;
  localparam logic [4:0] ALU_AND = 5'b01000;
  localparam logic [4:0] ALU_OR  = 5'b00100;
  localparam logic [4:0] ALU_EOR = 5'b00010;
  localparam logic [4:0] ALU_SR  = 5'b00001;

  localparam logic [2:0] MAX_SH = 3'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } flags_t;

  state_t     state_q, state_d;
  logic [2:0] op_q,    op_d;
  logic [7:0] a_q,     a_d;     // original A, returned by CMP/NOP
  logic [7:0] wrk_q,   wrk_d;   // ALU A operand; carries the running ASL value
  logic [7:0] b_q,     b_d;     // effective B (inverted for SBC/CMP)
  logic       cin_q,   cin_d;
  logic [2:0] cnt_q,   cnt_d;   // ASL iterations remaining including current
  logic [7:0] rsp_q,   rsp_d;
  flags_t     flg_q,   flg_d;

  flags_t     flg_in;
  logic [2:0] shamt_c;
  logic       sum_v;
  logic       res_z;

  // A coincident flag write is visible to the command's carry-in.
  assign flg_in  = flags_wr ? flags_t'(flags_wr_data) : flg_q;
  assign shamt_c = (cmd_shamt == 3'd0)   ? 3'd1   :
                   (cmd_shamt > MAX_SH)  ? MAX_SH : cmd_shamt;
  // ALU has no overflow output; derive it from operand/result signs.
  assign sum_v   = (a_q[7] == b_q[7]) && (alu_result[7] != a_q[7]);
  assign res_z   = (alu_result == 8'h00);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    wrk_d   = wrk_q;
    b_d     = b_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    flg_d   = flg_q;
    alu_op  = 5'b00000;

    case (state_q)
      IDLE: begin
        if (flags_wr) flg_d = flags_t'(flags_wr_data);
        if (cmd_valid) begin
          state_d = EXEC;
          op_d    = cmd_op;
          a_d     = cmd_a;
          wrk_d   = cmd_a;
          cnt_d   = shamt_c;
          case (cmd_op)
            OP_ADC:                 begin b_d = cmd_b;  cin_d = flg_in.c; end
            OP_SBC:                 begin b_d = ~cmd_b; cin_d = flg_in.c; end
            OP_CMP:                 begin b_d = ~cmd_b; cin_d = 1'b1;     end
            OP_AND, OP_ORA, OP_EOR: begin b_d = cmd_b;  cin_d = 1'b0;     end
            default:                begin b_d = 8'h00;  cin_d = 1'b0;     end
          endcase
        end
      end

      EXEC: begin
        state_d = DONE;
        case (op_q)
          OP_ADC, OP_SBC: begin
            alu_op = ALU_SUM;
            rsp_d  = alu_result;
            flg_d  = '{n: alu_result[7], v: sum_v, z: res_z, c: alu_carry_out};
          end
          OP_CMP: begin
            alu_op  = ALU_SUM;
            rsp_d   = a_q;
            flg_d.n = alu_result[7];
            flg_d.z = res_z;
            flg_d.c = alu_carry_out;
          end
          OP_AND, OP_ORA, OP_EOR: begin
            alu_op  = (op_q == OP_AND) ? ALU_AND :
                      (op_q == OP_ORA) ? ALU_OR  : ALU_EOR;
            rsp_d   = alu_result;
            flg_d.n = alu_result[7];
            flg_d.z = res_z;
          end
          OP_ASL: begin
            alu_op = ALU_SR;
            if (cnt_q > 3'd1) begin
              // Not the last step: recirculate and stay in EXEC.
              state_d = EXEC;
              wrk_d   = alu_result;
              cnt_d   = cnt_q - 3'd1;
            end else begin
              rsp_d   = alu_result;
              flg_d.n = alu_result[7];
              flg_d.z = res_z;
              flg_d.c = wrk_q[7];   // bit shifted out by the final step
            end
          end
          default: rsp_d = a_q;     // NOP
        endcase
      end

      DONE: if (rsp_ready) state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      a_q     <= 8'h00;
      wrk_q   <= 8'h00;
      b_q     <= 8'h00;
      cin_q   <= 1'b0;
      cnt_q   <= 3'd0;
      rsp_q   <= 8'h00;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      wrk_q   <= wrk_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      flg_q   <= flg_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == DONE);
  assign rsp_data     = rsp_q;
  assign alu_a        = wrk_q;
  assign alu_b        = b_q;
  assign alu_carry_in = cin_q;
  assign flag_n       = flg_q.n;
  assign flag_v       = flg_q.v;
  assign flag_z       = flg_q.z;
  assign flag_c       = flg_q.c;

`ifdef ALU_SEQ_CMD_COUNT_EN
  logic [15:0] cnt_rsp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_rsp_q <= 16'h0000;
    else if (rsp_valid && rsp_ready) cnt_rsp_q <= cnt_rsp_q + 16'h0001;
  end

  assign cmd_count = cnt_rsp_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_shamt;
  logic       flags_wr;
  logic [3:0] flags_wr_data;
  logic [7:0] alu_a, alu_b;
  logic [4:0] alu_op;
  logic       alu_carry_in;
  logic [7:0] alu_result;
  logic       alu_carry_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       flag_n, flag_v, flag_z, flag_c;
`ifdef ALU_SEQ_CMD_COUNT_EN
  logic [15:0] cmd_count;
`endif

  int checks = 0;
  int passes = 0;
  logic [3:0] m_flags = 4'h0;   // model of the flag register {N,V,Z,C}

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
    .flags_wr(flags_wr), .flags_wr_data(flags_wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z), .flag_c(flag_c)
`ifdef ALU_SEQ_CMD_COUNT_EN
    , .cmd_count(cmd_count)
`endif
  );

  // Combinational ALU stand-in.
  always_comb begin
    alu_result    = 8'h00;
    alu_carry_out = 1'b0;
    case (alu_op)
      5'b10000: {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
      5'b01000: alu_result = alu_a & alu_b;
      5'b00100: alu_result = alu_a | alu_b;
      5'b00010: alu_result = alu_a ^ alu_b;
      5'b00001: begin alu_result = {alu_a[6:0], 1'b0}; alu_carry_out = alu_a[7]; end
      default: ;
    endcase
  end

  function automatic logic [4:0] exp_aluop(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd6: return 5'b10000;
      3'd2:             return 5'b01000;
      3'd3:             return 5'b00100;
      3'd4:             return 5'b00010;
      3'd5:             return 5'b00001;
      default:          return 5'b00000;
    endcase
  endfunction

  function automatic int sx(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  // Reference: plain integer arithmetic on the 6502-style instruction rules.
  task automatic ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] sh, input logic [3:0] fin,
                           output logic [7:0] res, output logic [3:0] fo, output int lat);
    int s, sr, n, c;
    c   = int'(fin[0]);
    fo  = fin;
    res = a;
    lat = 2;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b) + c;  sr = sx(a) + sx(b) + c;
        res = 8'(s);
        fo = {res[7], (sr > 127 || sr < -128), res == 8'h00, s > 255};
      end
      3'd1: begin
        s = int'(a) - int'(b) - (1 - c);  sr = sx(a) - sx(b) - (1 - c);
        res = 8'(s);
        fo = {res[7], (sr > 127 || sr < -128), res == 8'h00, s >= 0};
      end
      3'd2, 3'd3, 3'd4: begin
        res = (op == 3'd2) ? (a & b) : (op == 3'd3) ? (a | b) : (a ^ b);
        fo = {res[7], fin[2], res == 8'h00, fin[0]};
      end
      3'd5: begin
        n = (sh == 3'd0) ? 1 : int'(sh);
        s = int'(a) << n;
        res = 8'(s);
        fo = {res[7], fin[2], res == 8'h00, ((int'(a) >> (8 - n)) & 1) == 1};
        lat = n + 1;
      end
      3'd6: begin
        s = int'(a) - int'(b);
        res = a;
        fo = {s[7], fin[2], a == b, a >= b};
      end
      default: ;
    endcase
  endtask

  // Issue one command, check timing/result/flags, hold the response for
  // 'hold' cycles (poking flags_wr meanwhile), then complete the transfer.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sh, input logic fw, input logic [3:0] fwd,
                        input int hold, input string tag);
    logic [7:0] er, r0;
    logic [3:0] ef, fin, obs;
    int lat, cyc, w;
    fin = fw ? fwd : m_flags;
    ref_model(op, a, b, sh, fin, er, ef, lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh;
    flags_wr = fw; flags_wr_data = fwd; rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (!cmd_ready) $display("FAIL %s accept: cmd_ready never seen", tag); else passes++;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; flags_wr = 1'b0;
    checks++;
    if (alu_op !== exp_aluop(op))
      $display("FAIL %s alu_op: got %b want %b", tag, alu_op, exp_aluop(op));
    else passes++;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != lat) $display("FAIL %s latency: got T+%0d want T+%0d", tag, cyc, lat); else passes++;
    checks++;
    if (rsp_data !== er) $display("FAIL %s rsp_data: got %h want %h", tag, rsp_data, er); else passes++;
    obs = {flag_n, flag_v, flag_z, flag_c};
    checks++;
    if (obs !== ef) $display("FAIL %s flags NVZC: got %b want %b", tag, obs, ef); else passes++;
    r0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      flags_wr = 1'b1; flags_wr_data = ~ef;
      @(negedge clk);
      obs = {flag_n, flag_v, flag_z, flag_c};
      checks++;
      if (!rsp_valid || cmd_ready || rsp_data !== r0 || obs !== ef)
        $display("FAIL %s hold%0d: valid=%b ready=%b data=%h flags=%b want 1 0 %h %b",
                 tag, i, rsp_valid, cmd_ready, rsp_data, obs, r0, ef);
      else passes++;
    end
    flags_wr = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid || !cmd_ready)
      $display("FAIL %s transfer: rsp_valid=%b cmd_ready=%b want 0 1", tag, rsp_valid, cmd_ready);
    else passes++;
    m_flags = ef;
  endtask

  task automatic set_flags(input logic [3:0] f);
    logic [3:0] obs;
    @(negedge clk);
    flags_wr = 1'b1; flags_wr_data = f;
    @(negedge clk);
    flags_wr = 1'b0;
    m_flags = f;
    obs = {flag_n, flag_v, flag_z, flag_c};
    checks++;
    if (obs !== f) $display("FAIL set_flags: got %b want %b", obs, f); else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_shamt = 3'd0; flags_wr = 1'b0; flags_wr_data = 4'h0; rsp_ready = 1'b0;
    #23;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset handshake: ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
    else passes++;
    checks++;
    if (rsp_data !== 8'h00) $display("FAIL reset rsp_data: got %h want 00", rsp_data); else passes++;
    checks++;
    if ({flag_n, flag_v, flag_z, flag_c} !== 4'h0)
      $display("FAIL reset flags: got %b want 0000", {flag_n, flag_v, flag_z, flag_c});
    else passes++;
    checks++;
    if (alu_op !== 5'b0 || alu_a !== 8'h00 || alu_b !== 8'h00)
      $display("FAIL reset alu: op=%b a=%h b=%h want 0 0 0", alu_op, alu_a, alu_b);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    m_flags = 4'h0;
  endtask

  task automatic test_directed();
    set_flags(4'b0000);
    do_cmd(3'd0, 8'h50, 8'h50, 3'd0, 1'b0, 4'h0, 0, "adc_50_50");
    do_cmd(3'd1, 8'h00, 8'h01, 3'd0, 1'b1, 4'b0001, 0, "sec_sbc");
    set_flags(4'b0100);
    do_cmd(3'd6, 8'h40, 8'h40, 3'd0, 1'b0, 4'h0, 0, "cmp_eq_vkeep");
    do_cmd(3'd5, 8'h81, 8'h00, 3'd3, 1'b0, 4'h0, 0, "asl_x3");
    do_cmd(3'd5, 8'h81, 8'h00, 3'd0, 1'b0, 4'h0, 0, "asl_x0");
    do_cmd(3'd5, 8'hC3, 8'h00, 3'd7, 1'b0, 4'h0, 0, "asl_x7");
    do_cmd(3'd7, 8'h5A, 8'hFF, 3'd0, 1'b0, 4'h0, 0, "nop");
    do_cmd(3'd2, 8'hF0, 8'h0F, 3'd0, 1'b0, 4'h0, 0, "and_zero");
  endtask

  task automatic test_backpressure();
    do_cmd(3'd0, 8'h7F, 8'h01, 3'd0, 1'b1, 4'b0000, 5, "bp_adc");
    do_cmd(3'd4, 8'hAA, 8'h55, 3'd0, 1'b0, 4'h0, 5, "bp_eor");
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_a = 8'h81; cmd_shamt = 3'd5; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_op !== 5'b0 ||
        {flag_n, flag_v, flag_z, flag_c} !== 4'h0)
      $display("FAIL reset_mid: ready=%b valid=%b op=%b flags=%b want 1 0 00000 0000",
               cmd_ready, rsp_valid, alu_op, {flag_n, flag_v, flag_z, flag_c});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    m_flags = 4'h0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0) $display("FAIL reset_mid stray rsp: got %0d cycles want 0", seen); else passes++;
  endtask

  task automatic test_random();
    logic [2:0] op, sh;
    logic [7:0] a, b;
    logic       fw;
    logic [3:0] fwd;
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = 8'($urandom);
      b   = 8'($urandom);
      sh  = 3'($urandom_range(0, 7));
      fw  = ($urandom_range(0, 3) == 0);
      fwd = 4'($urandom);
      do_cmd(op, a, b, sh, fw, fwd, $urandom_range(0, 2), "rand");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      do_cmd(3'(i), 8'(i * 37 + 5), 8'(i * 91 + 3), 3'(i), 1'b0, 4'h0, 0, "b2b");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
